// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and the fetch-stage state encoding.
package cpu_pkg;

  localparam int          CPU_XLEN      = 32;
  localparam logic [31:0] CPU_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] CPU_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DROP  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_unit_if #(
  parameter int XLEN = cpu_pkg::CPU_XLEN
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/if_id_reg.sv
// Generic stage register holding {pc, instr, valid}; flush overrides any write.
module if_id_reg #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_INSTR = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] pc_i,
  input  logic [WIDTH-1:0] instr_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] instr_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] instr_q;
  logic             valid_q;

  // pc is left untouched on flush: it is meaningless once valid drops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= '0;
      instr_q <= RESET_INSTR;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      instr_q <= RESET_INSTR;
      valid_q <= 1'b0;
    end else if (we_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
      valid_q <= 1'b1;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem handshake with redirect-while-waiting,
// one-entry skid buffer for load-use stalls, and the IF/ID register.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int            XLEN      = CPU_XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(CPU_RESET_PC),
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(CPU_NOP_INSTR)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mux_to_pc,
  input  logic [XLEN-1:0]  branch_target,
  input  logic             IF_Flush,
  input  logic             stall,
  fetch_unit_if.master     imem,
  output logic [XLEN-1:0]  if_id_pc,
  output logic [XLEN-1:0]  if_id_instr,
  output logic             if_id_valid
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pending_q, pending_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [XLEN-1:0] skid_instr_q, skid_instr_d;

  logic            ifid_we;
  logic [XLEN-1:0] ifid_pc_d;
  logic [XLEN-1:0] ifid_instr_d;
  logic [XLEN-1:0] pc_plus4;

  assign pc_plus4 = pc_q + XLEN'(4);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      pending_q    <= '0;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_q    <= pending_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pending_d    = pending_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    ifid_we      = 1'b0;
    ifid_pc_d    = pc_q;
    ifid_instr_d = imem.imem_rdata;

    unique case (state_q)
      FETCH: begin
        if (imem.imem_ready) begin
          if (mux_to_pc) begin
            pc_d = branch_target;
          end else if (stall) begin
            skid_pc_d    = pc_q;
            skid_instr_d = imem.imem_rdata;
            pc_d         = pc_plus4;
            state_d      = HOLD;
          end else begin
            ifid_we = 1'b1;
            pc_d    = pc_plus4;
          end
        end else if (mux_to_pc) begin
          // The outstanding request cannot be withdrawn; park the target.
          pending_d = branch_target;
          state_d   = DROP;
        end
      end

      DROP: begin
        if (imem.imem_ready) begin
          pc_d    = mux_to_pc ? branch_target : pending_q;
          state_d = FETCH;
        end else if (mux_to_pc) begin
          pending_d = branch_target;
        end
      end

      HOLD: begin
        if (mux_to_pc) begin
          pc_d    = branch_target;
          state_d = FETCH;
        end else if (!stall) begin
          ifid_we      = 1'b1;
          ifid_pc_d    = skid_pc_q;
          ifid_instr_d = skid_instr_q;
          state_d      = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Request drops combinationally with reset so an in-flight fetch is abandoned at once.
  assign imem.imem_req  = reset_n && (state_q != HOLD);
  assign imem.imem_addr = pc_q;

  if_id_reg #(
    .WIDTH      (XLEN),
    .RESET_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .we_i    (ifid_we),
    .flush_i (IF_Flush),
    .pc_i    (ifid_pc_d),
    .instr_i (ifid_instr_d),
    .pc_o    (if_id_pc),
    .instr_o (if_id_instr),
    .valid_o (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; expected IF/ID writes go through a scoreboard queue.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        mux_to_pc = 1'b0;
  logic        IF_Flush = 1'b0;
  logic        stall = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_t;

  ifid_t exp_q[$];
  int    total = 0;
  int    bad   = 0;

  fetch_unit_if ifc ();

  function automatic logic [31:0] instr_at(input logic [31:0] a);
    return a ^ 32'h1357_9BD1;
  endfunction

  assign ifc.imem_ready = ready;
  assign ifc.imem_rdata = instr_at(ifc.imem_addr);

  fetch_unit dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mux_to_pc    (mux_to_pc),
    .branch_target(branch_target),
    .IF_Flush     (IF_Flush),
    .stall        (stall),
    .imem         (ifc.master),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr),
    .if_id_valid  (if_id_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      $error("check %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc);
    exp_q.push_back('{pc: pc, instr: instr_at(pc)});
  endtask

  task automatic pop_check(input string tag);
    ifid_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_pc"}, if_id_pc, e.pc);
      chk({tag, "_instr"}, if_id_instr, e.instr);
      chk({tag, "_valid"}, {31'd0, if_id_valid}, 32'd1);
    end
  endtask

  initial begin
    // Async reset before any clock edge
    #1 reset_n = 1'b0;
    #1;
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_instr", if_id_instr, 32'h13);
    chk("rst_pc", if_id_pc, 32'd0);
    chk("rst_req", {31'd0, ifc.imem_req}, 32'd0);
    tick();
    chk("rst_valid2", {31'd0, if_id_valid}, 32'd0);
    reset_n = 1'b1;
    ready   = 1'b1;
    #1;
    chk("rel_req", {31'd0, ifc.imem_req}, 32'd1);
    chk("addr0", ifc.imem_addr, 32'd0);

    // Back-to-back fetches
    push(32'd0);
    tick();
    pop_check("f0");
    chk("addr4", ifc.imem_addr, 32'd4);
    push(32'd4);
    tick();
    pop_check("f4");
    chk("addr8", ifc.imem_addr, 32'd8);

    // Stall as fetch of pc=8 completes: goes to skid
    stall = 1'b1;
    tick();
    chk("hold_req", {31'd0, ifc.imem_req}, 32'd0);
    chk("hold_pc", if_id_pc, 32'd4);
    chk("hold_instr", if_id_instr, instr_at(32'd4));
    tick();
    chk("hold2_req", {31'd0, ifc.imem_req}, 32'd0);
    chk("hold2_instr", if_id_instr, instr_at(32'd4));
    stall = 1'b0;
    push(32'd8);
    tick();
    pop_check("skid8");
    chk("addr12", ifc.imem_addr, 32'd12);
    chk("req12", {31'd0, ifc.imem_req}, 32'd1);

    // Redirect with flush while the fetch of pc=12 completes
    mux_to_pc     = 1'b1;
    IF_Flush      = 1'b1;
    branch_target = 32'h40;
    tick();
    mux_to_pc = 1'b0;
    IF_Flush  = 1'b0;
    chk("br_addr", ifc.imem_addr, 32'h40);
    chk("br_valid", {31'd0, if_id_valid}, 32'd0);
    chk("br_instr", if_id_instr, 32'h13);
    push(32'h40);
    tick();
    pop_check("f40");
    chk("addr44", ifc.imem_addr, 32'h44);

    // Redirect during a wait state: old request completes and is dropped
    ready         = 1'b0;
    mux_to_pc     = 1'b1;
    branch_target = 32'h80;
    tick();
    mux_to_pc = 1'b0;
    chk("drop_addr1", ifc.imem_addr, 32'h44);
    chk("drop_req1", {31'd0, ifc.imem_req}, 32'd1);
    tick();
    chk("drop_addr2", ifc.imem_addr, 32'h44);
    ready = 1'b1;
    tick();
    chk("drop_next", ifc.imem_addr, 32'h80);
    chk("drop_ifid", if_id_pc, 32'h40);
    chk("drop_ifid_instr", if_id_instr, instr_at(32'h40));

    // Flush beats stall
    ready    = 1'b0;
    stall    = 1'b1;
    IF_Flush = 1'b1;
    tick();
    IF_Flush = 1'b0;
    chk("fs_valid", {31'd0, if_id_valid}, 32'd0);
    chk("fs_instr", if_id_instr, 32'h13);

    // Fill skid with pc=0x80, then redirect out of HOLD
    ready = 1'b1;
    tick();
    chk("h2_req", {31'd0, ifc.imem_req}, 32'd0);
    mux_to_pc     = 1'b1;
    branch_target = 32'h100;
    tick();
    mux_to_pc = 1'b0;
    stall     = 1'b0;
    chk("hr_addr", ifc.imem_addr, 32'h100);
    chk("hr_req", {31'd0, ifc.imem_req}, 32'd1);
    chk("hr_valid", {31'd0, if_id_valid}, 32'd0);
    push(32'h100);
    tick();
    pop_check("f100");

    // PC wrap
    mux_to_pc     = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    tick();
    mux_to_pc = 1'b0;
    chk("wrap_addr", ifc.imem_addr, 32'hFFFF_FFFC);
    chk("wrap_ifid_held", if_id_pc, 32'h100);
    push(32'hFFFF_FFFC);
    tick();
    pop_check("fwrap");
    chk("wrap_next", ifc.imem_addr, 32'd0);

    // Async reset in the middle of a wait state
    ready = 1'b0;
    tick();
    chk("mw_req", {31'd0, ifc.imem_req}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_req", {31'd0, ifc.imem_req}, 32'd0);
    chk("ar_valid", {31'd0, if_id_valid}, 32'd0);
    chk("ar_instr", if_id_instr, 32'h13);
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    chk("ar_rel_req", {31'd0, ifc.imem_req}, 32'd1);
    chk("ar_rel_addr", ifc.imem_addr, 32'd0);

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
